// File: rtl/lfsr_gen2_pkg.sv
// Shared types and tap constants for the lfsr_gen2 Galois LFSR source.
package lfsr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } lfsr_state_e;

  localparam logic [19:0] LFSR_TAPS_20 = 20'h890B0;
  localparam logic [3:0]  LFSR_TAPS_4  = 4'b1100;

endpackage

// File: rtl/lfsr_gen2_if.sv
// Control, seed and output handshake bundle of lfsr_gen2; master is the generator side.
interface lfsr_gen2_if
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 20
);

  // Handshake: out_vld stays high with out stable until a cycle where out_rdy is
  // also high; that cycle is a transfer and out shows the next word afterwards.
  logic             enb;
  logic             seed_load;
  logic [WIDTH-1:0] seed;
  logic             seed_err;
  logic             out_vld;
  logic             out_rdy;
  logic [WIDTH-1:0] out;
  logic             wrap;
  lfsr_state_e      state;

  modport master (
    input  enb, seed_load, seed, out_rdy,
    output seed_err, out_vld, out, wrap, state
  );

  modport slave (
    output enb, seed_load, seed, out_rdy,
    input  seed_err, out_vld, out, wrap, state
  );

endinterface

// File: rtl/lfsr_gen2_step.sv
// One combinational Galois shift: shift right, fold TAPS in when bit 0 falls out.
module lfsr_gen2_step #(
  parameter int               WIDTH = 20,
  parameter logic [WIDTH-1:0] TAPS  = 20'h890B0
) (
  input  logic [WIDTH-1:0] i_v,
  output logic [WIDTH-1:0] o_v
);

  assign o_v = {1'b0, i_v[WIDTH-1:1]} ^ (i_v[0] ? TAPS : '0);

endmodule

// File: rtl/lfsr_gen2.sv
// Galois LFSR word source with valid/ready output, seed loading and optional
// period-wrap detection (build with LFSR_GEN2_WRAP_EN to enable wrap).
module lfsr_gen2
  import lfsr_pkg::*;
#(
  parameter int               WIDTH      = 20,
  parameter logic [WIDTH-1:0] TAPS       = LFSR_TAPS_20,
  parameter int               STEPS      = 1,
  parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1)
) (
  input logic         clk,
  input logic         rst_n,
  lfsr_gen2_if.master bus
);

  lfsr_state_e      r_fsm;
  lfsr_state_e      w_fsm_nxt;
  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] w_adv;
  logic [WIDTH-1:0] w_chain [STEPS+1];
  logic             w_xfer;
  logic             w_seed_ok;
  logic             w_seed_bad;
  logic             r_seed_err;

  assign w_chain[0] = r_state;

  for (genvar g = 0; g < STEPS; g++) begin : g_step
    lfsr_gen2_step #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
    ) u_step (
      .i_v (w_chain[g]),
      .o_v (w_chain[g+1])
    );
  end

  assign w_adv      = w_chain[STEPS];
  assign w_xfer     = (r_fsm == RUN) && bus.out_rdy;
  assign w_seed_ok  = bus.seed_load && (bus.seed != '0);
  assign w_seed_bad = bus.seed_load && (bus.seed == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fsm <= IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  // RUN only falls back once the pending word has actually been taken.
  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      IDLE:    if (bus.enb) w_fsm_nxt = RUN;
      RUN:     if (!bus.enb && bus.out_rdy) w_fsm_nxt = IDLE;
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.out_vld = (r_fsm == RUN);
    bus.state   = r_fsm;
  end

  // A valid seed load wins over a same-cycle advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RESET_SEED;
      r_seed_err <= 1'b0;
    end else begin
      r_seed_err <= w_seed_bad;
      if (w_seed_ok)   r_state <= bus.seed;
      else if (w_xfer) r_state <= w_adv;
    end
  end

  assign bus.out      = r_state;
  assign bus.seed_err = r_seed_err;

`ifdef LFSR_GEN2_WRAP_EN
  logic [WIDTH-1:0] r_ref;
  logic             r_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref  <= RESET_SEED;
      r_wrap <= 1'b0;
    end else begin
      if (w_seed_ok) r_ref <= bus.seed;
      r_wrap <= w_xfer && !w_seed_ok && (w_adv == r_ref);
    end
  end

  assign bus.wrap = r_wrap;
`else
  assign bus.wrap = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_gen2.sv
// Bench for lfsr_gen2: default, STEPS=2 and 4-bit instances share clock and reset.
module tb_lfsr_gen2;
  import lfsr_pkg::*;

  localparam logic [19:0] T20 = 20'h890B0;
  localparam logic [3:0]  T4  = 4'b1100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [21:0] exp_q[$];
  logic [19:0] m_out;
  logic        m_vld;

  always #5 clk = ~clk;

  lfsr_gen2_if #(.WIDTH(20)) bus_a ();
  lfsr_gen2_if #(.WIDTH(20)) bus_b ();
  lfsr_gen2_if #(.WIDTH(4))  bus_c ();

  lfsr_gen2 #(.WIDTH(20), .TAPS(T20), .STEPS(1), .RESET_SEED(20'h00001)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.master));
  lfsr_gen2 #(.WIDTH(20), .TAPS(T20), .STEPS(2), .RESET_SEED(20'h00001)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.master));
  lfsr_gen2 #(.WIDTH(4), .TAPS(T4), .STEPS(1), .RESET_SEED(4'h1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .bus(bus_c.master));

  function automatic logic [63:0] gal_step(input logic [63:0] v, input logic [63:0] taps);
    logic [63:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ taps;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle on the default instance, predict, then check its outputs.
  task automatic cycle_a(input logic enb, input logic rdy, input logic ld, input logic [19:0] sd);
    logic [21:0] e;
    logic [63:0] t;
    logic [19:0] nxt;
    logic        nvld;
    logic        nerr;
    bus_a.enb = enb; bus_a.out_rdy = rdy; bus_a.seed_load = ld; bus_a.seed = sd;
    nxt = m_out;
    t   = gal_step({44'd0, m_out}, {44'd0, T20});
    if (ld && sd != 20'd0) nxt = sd;
    else if (m_vld && rdy) nxt = t[19:0];
    nerr = ld && (sd == 20'd0);
    nvld = m_vld ? (enb || !rdy) : enb;
    exp_q.push_back({nerr, nvld, nxt});
    m_out = nxt;
    m_vld = nvld;
    tick();
    e = exp_q.pop_front();
    n_tests++;
    if (bus_a.out !== e[19:0]) begin
      n_fail++; $display("FAIL sb_out: got %h expected %h", bus_a.out, e[19:0]);
    end
    n_tests++;
    if (bus_a.out_vld !== e[20]) begin
      n_fail++; $display("FAIL sb_vld: got %b expected %b", bus_a.out_vld, e[20]);
    end
    n_tests++;
    if (bus_a.seed_err !== e[21]) begin
      n_fail++; $display("FAIL sb_seed_err: got %b expected %b", bus_a.seed_err, e[21]);
    end
  endtask

  task automatic test_reset();
    #12;
    n_tests++;
    if (bus_a.out !== 20'h00001 || bus_b.out !== 20'h00001 || bus_c.out !== 4'h1) begin
      n_fail++; $display("FAIL reset_out: got %h %h %h expected 1", bus_a.out, bus_b.out, bus_c.out);
    end
    n_tests++;
    if (bus_a.out_vld !== 1'b0 || bus_b.out_vld !== 1'b0 || bus_c.out_vld !== 1'b0) begin
      n_fail++; $display("FAIL reset_vld: got %b%b%b expected 000", bus_a.out_vld, bus_b.out_vld, bus_c.out_vld);
    end
    n_tests++;
    if (bus_a.seed_err !== 1'b0 || bus_a.wrap !== 1'b0 || bus_c.wrap !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulses: got %b%b%b expected 000", bus_a.seed_err, bus_a.wrap, bus_c.wrap);
    end
    n_tests++;
    if (bus_a.state !== IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d expected %0d", bus_a.state, IDLE);
    end
    tick();
    rst_n = 1'b1;
    m_out = 20'h00001;
    m_vld = 1'b0;
  endtask

  task automatic test_sequence();
    logic [19:0] obs [3];
    logic [19:0] ref_seq [3];
    ref_seq[0] = 20'h00001; ref_seq[1] = 20'h890B0; ref_seq[2] = 20'h44858;
    for (int i = 0; i < 3; i++) begin
      cycle_a(1'b1, 1'b1, 1'b0, 20'd0);
      obs[i] = bus_a.out;
    end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (obs[i] !== ref_seq[i]) begin
        n_fail++; $display("FAIL seq_word%0d: got %h expected %h", i, obs[i], ref_seq[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [19:0] held;
    logic [63:0] t;
    held = m_out;
    for (int i = 0; i < 5; i++) begin
      cycle_a(1'b1, 1'b0, 1'b0, 20'd0);
      n_tests++;
      if (bus_a.out !== held || bus_a.out_vld !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold: got %h/%b expected %h/1", bus_a.out, bus_a.out_vld, held);
      end
    end
    for (int i = 0; i < 3; i++) cycle_a(1'b0, 1'b0, 1'b0, 20'd0);
    cycle_a(1'b0, 1'b1, 1'b0, 20'd0);
    t = gal_step({44'd0, held}, {44'd0, T20});
    n_tests++;
    if (bus_a.out !== t[19:0] || bus_a.out_vld !== 1'b0) begin
      n_fail++; $display("FAIL bp_drain: got %h/%b expected %h/0", bus_a.out, bus_a.out_vld, t[19:0]);
    end
    cycle_a(1'b0, 1'b0, 1'b0, 20'd0);
  endtask

  task automatic test_seed_load();
    cycle_a(1'b0, 1'b0, 1'b1, 20'h12345);
    n_tests++;
    if (bus_a.out !== 20'h12345) begin
      n_fail++; $display("FAIL seed_load: got %h expected 12345", bus_a.out);
    end
    cycle_a(1'b0, 1'b0, 1'b1, 20'h00000);
    n_tests++;
    if (bus_a.out !== 20'h12345 || bus_a.seed_err !== 1'b1) begin
      n_fail++; $display("FAIL seed_zero: got %h/%b expected 12345/1", bus_a.out, bus_a.seed_err);
    end
    cycle_a(1'b0, 1'b0, 1'b0, 20'd0);
    cycle_a(1'b1, 1'b0, 1'b0, 20'd0);
    cycle_a(1'b1, 1'b1, 1'b1, 20'hABCDE);
    n_tests++;
    if (bus_a.out !== 20'hABCDE) begin
      n_fail++; $display("FAIL seed_over_xfer: got %h expected abcde", bus_a.out);
    end
    cycle_a(1'b1, 1'b1, 1'b0, 20'd0);
    cycle_a(1'b0, 1'b1, 1'b0, 20'd0);
    cycle_a(1'b0, 1'b0, 1'b0, 20'd0);
  endtask

  task automatic test_steps2();
    bus_b.enb = 1'b1; bus_b.out_rdy = 1'b0;
    tick();
    n_tests++;
    if (bus_b.out !== 20'h00001 || bus_b.out_vld !== 1'b1) begin
      n_fail++; $display("FAIL s2_start: got %h/%b expected 00001/1", bus_b.out, bus_b.out_vld);
    end
    bus_b.enb = 1'b0; bus_b.out_rdy = 1'b1;
    tick();
    n_tests++;
    if (bus_b.out !== 20'h44858 || bus_b.out_vld !== 1'b0) begin
      n_fail++; $display("FAIL s2_advance: got %h/%b expected 44858/0", bus_b.out, bus_b.out_vld);
    end
    bus_b.out_rdy = 1'b0;
    tick();
    n_tests++;
    if (bus_b.out !== 20'h44858) begin
      n_fail++; $display("FAIL s2_idle_hold: got %h expected 44858", bus_b.out);
    end
  endtask

  task automatic test_wrap();
    logic [3:0]  mc;
    logic [63:0] t;
    logic        exp_w;
    mc = 4'h1;
    bus_c.enb = 1'b1; bus_c.out_rdy = 1'b1;
    tick();
    n_tests++;
    if (bus_c.wrap !== 1'b0 || bus_c.out !== 4'h1) begin
      n_fail++; $display("FAIL wrap_start: got %h/%b expected 1/0", bus_c.out, bus_c.wrap);
    end
    for (int k = 1; k <= 30; k++) begin
      tick();
      t  = gal_step({60'd0, mc}, {60'd0, T4});
      mc = t[3:0];
`ifdef LFSR_GEN2_WRAP_EN
      exp_w = (k == 15) || (k == 30);
`else
      exp_w = 1'b0;
`endif
      n_tests++;
      if (bus_c.out !== mc || bus_c.wrap !== exp_w) begin
        n_fail++; $display("FAIL wrap_xfer%0d: got %h/%b expected %h/%b", k, bus_c.out, bus_c.wrap, mc, exp_w);
      end
    end
    bus_c.enb = 1'b0;
    tick();
    bus_c.out_rdy = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) cycle_a(1'b1, 1'b1, 1'b0, 20'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus_a.out !== 20'h00001 || bus_a.out_vld !== 1'b0) begin
      n_fail++; $display("FAIL async_rst: got %h/%b expected 00001/0", bus_a.out, bus_a.out_vld);
    end
    n_tests++;
    if (bus_b.out !== 20'h00001 || bus_c.out !== 4'h1) begin
      n_fail++; $display("FAIL async_rst_all: got %h/%h expected 1/1", bus_b.out, bus_c.out);
    end
    tick();
    rst_n = 1'b1;
    m_out = 20'h00001;
    m_vld = 1'b0;
    for (int i = 0; i < 3; i++) cycle_a(1'b1, 1'b1, 1'b0, 20'd0);
    cycle_a(1'b0, 1'b1, 1'b0, 20'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.enb = 1'b0; bus_a.out_rdy = 1'b0; bus_a.seed_load = 1'b0; bus_a.seed = '0;
    bus_b.enb = 1'b0; bus_b.out_rdy = 1'b0; bus_b.seed_load = 1'b0; bus_b.seed = '0;
    bus_c.enb = 1'b0; bus_c.out_rdy = 1'b0; bus_c.seed_load = 1'b0; bus_c.seed = '0;
    test_reset();
    test_sequence();
    test_backpressure();
    test_seed_load();
    test_steps2();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
